arb_mux_4_1: RTL and testbench

Registered 4-input stream arbiter with a round-robin grant pointer. Each cycle it picks one valid input lane, moves that lane's data word into a single-entry output register, and reports which lane won as a 2-bit select. It sits directly upstream of the 4:1 mux datapath. The `out_sel` output is the select that the downstream mux tree consumes, so that tree can steer sideband lanes in step with `out_data`.

---
 rtl/arb_mux_4_1.sv | 134 +++++++++++++
 tb/tb_arb_mux_4_1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_4_1.sv
// arb_mux_4_1: registered 4-input stream arbiter feeding a 4:1 mux datapath.
//
// Each cycle one valid lane is granted, its data word is copied into a
// single-entry output register and the winning lane index is reported on
// out_sel so the downstream mux tree can steer sideband lanes in step.
//
// Build option:
//   ARB_MUX_ROUND_ROBIN_EN defined   -> round-robin scan starting at ptr
//   ARB_MUX_ROUND_ROBIN_EN undefined -> fixed priority, lane 0 highest
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   d0..d3   [W-1:0]    lane data words
//   in_vld   [3:0]      per-lane valid
//   in_rdy   [3:0]      per-lane ready, one-hot or zero
//   out_data [W-1:0]    registered data of the winning lane
//   out_sel  [1:0]      registered index of the winning lane
//   out_vld             output register holds a word
//   out_rdy             downstream accepts the word
module arb_mux_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [3:0]   in_vld,
  output logic [3:0]   in_rdy,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;
  logic         out_vld_q, out_vld_d;

  logic [1:0]   scan_base;
  logic [1:0]   lane;
  logic [1:0]   grant_idx;
  logic         grant_any;
  logic [3:0]   grant;
  logic         stage_free;
  logic         load;
  logic [W-1:0] win_data;

`ifdef ARB_MUX_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign scan_base = ptr_q;
`else
  assign scan_base = 2'd0;
`endif

  // First valid lane at or after scan_base, wrapping modulo 4.
  always_comb begin
    lane      = 2'd0;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      lane = scan_base + k[1:0];
      if (!grant_any && in_vld[lane]) begin
        grant_any = 1'b1;
        grant_idx = lane;
      end
    end
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  assign stage_free = !out_vld_q || out_rdy;
  assign in_rdy     = stage_free ? grant : 4'b0000;
  // in_rdy equals grant when free, so a granted lane is always a transfer.
  assign load       = stage_free && grant_any;

  always_comb begin
    win_data = d0;
    case (grant_idx)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_vld_d  = out_vld_q;
    if (load) begin
      out_data_d = win_data;
      out_sel_d  = grant_idx;
      out_vld_d  = 1'b1;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

`ifdef ARB_MUX_ROUND_ROBIN_EN
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = grant_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_sel_q  <= 2'd0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Testbench for arb_mux_4_1: directed steps followed by random traffic, all
// checked against a transaction-level model of the arbiter. Follows the
// ARB_MUX_ROUND_ROBIN_EN build option of the design.
module tb_arb_mux_4_1;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d [4];
  logic [3:0]   in_vld;
  logic [3:0]   in_rdy;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_vld;
  logic         out_rdy;

  int checks;
  int errors;

  // Reference model state
  logic         m_vld;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic [3:0]   obs_rdy;

  arb_mux_4_1 #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d0       (d[0]),
    .d1       (d[1]),
    .d2       (d[2]),
    .d3       (d[3]),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane served next: first valid lane counting upward from base, modulo 4.
  function automatic int pick(input logic [3:0] v, input int base);
    for (int k = 0; k < 4; k++) begin
      if (v[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_ptr  = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_vld"},  32'(out_vld),  32'(m_vld));
    chk({tag, "_data"}, 32'(out_data), 32'(m_data));
    chk({tag, "_sel"},  32'(out_sel),  32'(m_sel));
  endtask

  // Called at a falling edge with d[] already set; returns at the next one.
  task automatic step(input logic [3:0] v, input logic r);
    int         g;
    logic       free;
    logic [3:0] exp_rdy;
    in_vld  = v;
    out_rdy = r;
    #1;
    g       = pick(v, m_ptr);
    free    = !m_vld || r;
    exp_rdy = (free && g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_rdy = in_rdy;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    chk_outputs("pre");
    @(posedge clk);
    if (free && g >= 0) begin
      m_vld  = 1'b1;
      m_data = d[g];
      m_sel  = g;
`ifdef ARB_MUX_ROUND_ROBIN_EN
      m_ptr  = (g + 1) % 4;
`endif
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_lane;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    in_vld  = 4'b0000;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    model_reset();

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_vld",  32'(out_vld),  32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel",  32'(out_sel),  32'd0);
    rst_n = 1'b1;

    // Single lane
    d[2] = 4'hA;
    step(4'b0100, 1'b1);
    chk("single_rdy",  32'(obs_rdy),  32'b0100);
    chk("single_vld",  32'(out_vld),  32'd1);
    chk("single_data", 32'(out_data), 32'hA);
    chk("single_sel",  32'(out_sel),  32'd2);

    // Serve lane 3 so the rotation starts from lane 0
    step(4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) d[i] = W'(i + 5);
    for (int i = 0; i < 5; i++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
      exp_lane = 4'(i % 4);
`else
      exp_lane = 4'd0;
`endif
      step(4'b1111, 1'b1);
      chk("rot_sel",  32'(out_sel),  32'(exp_lane));
      chk("rot_data", 32'(out_data), 32'(exp_lane) + 32'd5);
    end

    // Skip and wrap: lane 2 leaves ptr at 3
    step(4'b0100, 1'b1);
    step(4'b0011, 1'b1);
    chk("wrap_first", 32'(obs_rdy), 32'b0001);
    step(4'b0011, 1'b1);
`ifdef ARB_MUX_ROUND_ROBIN_EN
    chk("wrap_second", 32'(obs_rdy), 32'b0010);
`else
    chk("wrap_second", 32'(obs_rdy), 32'b0001);
`endif

    // Backpressure
    for (int i = 0; i < 4; i++) d[i] = W'(4'hC - i);
    step(4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0);
      chk("bp_rdy",  32'(obs_rdy),  32'd0);
      chk("bp_data", 32'(out_data), 32'hC);
      chk("bp_sel",  32'(out_sel),  32'd0);
    end
    step(4'b1111, 1'b1);
`ifdef ARB_MUX_ROUND_ROBIN_EN
    chk("bp_release", 32'(obs_rdy), 32'b0010);
`else
    chk("bp_release", 32'(obs_rdy), 32'b0001);
`endif

    // Reset while stalled with a word held
    step(4'b0001, 1'b1);
    step(4'b1111, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  32'(out_vld),  32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sel",  32'(out_sel),  32'd0);
    model_reset();
    chk("mid_rst_rdy", 32'(in_rdy), 32'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    chk("post_rst_grant", 32'(obs_rdy), 32'b0001);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) d[i] = W'($urandom);
      step(4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
